// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM and MM:SS BCD datapath
// Optional saturate-at-top-count behaviour enabled by defining STOPWATCH_SAT_EN.
module stopwatch_ctrl #(
    parameter int MIN_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] digit_blank,
    output logic       running,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ADJ   = 2'd3
    } state_t;

    localparam logic [3:0] L_MT_MAX = 4'(MIN_TENS_MAX);

    state_t     r_state, w_state_nxt;
    logic       r_prev_1hz, r_prev_2hz, r_prev_blink, r_prev_pause, r_prev_reset;
    logic       r_blink_ph, w_blink_nxt;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt, w_mo, w_st, w_so;
    logic [3:0] r_blank, w_blank_nxt;
    logic       r_running;
    logic       w_rise_1hz, w_rise_2hz, w_rise_blink, w_rise_pause, w_rise_reset;
    logic       w_at_max;

    assign w_rise_1hz   = tick_1hz   & ~r_prev_1hz;
    assign w_rise_2hz   = tick_2hz   & ~r_prev_2hz;
    assign w_rise_blink = tick_blink & ~r_prev_blink;
    assign w_rise_pause = btn_pause  & ~r_prev_pause;
    assign w_rise_reset = btn_reset  & ~r_prev_reset;
    assign w_at_max     = (r_mt == L_MT_MAX) && (r_mo == 4'd9) &&
                          (r_st == 4'd5) && (r_so == 4'd9);

    always_comb begin
        w_state_nxt = r_state;
        w_blink_nxt = r_blink_ph ^ w_rise_blink;
        w_mt = r_mt;
        w_mo = r_mo;
        w_st = r_st;
        w_so = r_so;

        if (sw_adj)
            w_state_nxt = S_ADJ;
        else if (r_state == S_ADJ)
            w_state_nxt = S_PAUSE;
        else if (w_rise_reset)
            w_state_nxt = S_IDLE;
        else if (w_rise_pause) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_PAUSE;
                S_PAUSE: w_state_nxt = S_RUN;
                default: w_state_nxt = r_state;
            endcase
        end

        // Clear beats both counting and adjusting when they coincide.
        if (w_rise_reset) begin
            w_mt = 4'd0;
            w_mo = 4'd0;
            w_st = 4'd0;
            w_so = 4'd0;
        end else if (r_state == S_RUN && w_rise_1hz) begin
            if (w_at_max) begin
`ifdef STOPWATCH_SAT_EN
                if (!sw_adj)
                    w_state_nxt = S_PAUSE;
`else
                w_mt = 4'd0;
                w_mo = 4'd0;
                w_st = 4'd0;
                w_so = 4'd0;
`endif
            end else if (r_so != 4'd9) begin
                w_so = r_so + 4'd1;
            end else begin
                w_so = 4'd0;
                if (r_st != 4'd5) begin
                    w_st = r_st + 4'd1;
                end else begin
                    w_st = 4'd0;
                    if (r_mo != 4'd9) begin
                        w_mo = r_mo + 4'd1;
                    end else begin
                        w_mo = 4'd0;
                        w_mt = r_mt + 4'd1;
                    end
                end
            end
        end else if (r_state == S_ADJ && w_rise_2hz) begin
            if (sw_sel) begin
                if (r_so != 4'd9) begin
                    w_so = r_so + 4'd1;
                end else begin
                    w_so = 4'd0;
                    w_st = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
                end
            end else begin
                if (r_mo != 4'd9) begin
                    w_mo = r_mo + 4'd1;
                end else begin
                    w_mo = 4'd0;
                    w_mt = (r_mt == L_MT_MAX) ? 4'd0 : r_mt + 4'd1;
                end
            end
        end

        w_blank_nxt = 4'b0000;
        if (w_state_nxt == S_ADJ && w_blink_nxt)
            w_blank_nxt = sw_sel ? 4'b0011 : 4'b1100;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev_1hz   <= 1'b0;
            r_prev_2hz   <= 1'b0;
            r_prev_blink <= 1'b0;
            r_prev_pause <= 1'b0;
            r_prev_reset <= 1'b0;
            r_blink_ph   <= 1'b0;
            r_mt         <= 4'd0;
            r_mo         <= 4'd0;
            r_st         <= 4'd0;
            r_so         <= 4'd0;
            r_blank      <= 4'b0000;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_1hz   <= tick_1hz;
            r_prev_2hz   <= tick_2hz;
            r_prev_blink <= tick_blink;
            r_prev_pause <= btn_pause;
            r_prev_reset <= btn_reset;
            r_blink_ph   <= w_blink_nxt;
            r_mt         <= w_mt;
            r_mo         <= w_mo;
            r_st         <= w_st;
            r_so         <= w_so;
            r_blank      <= w_blank_nxt;
            r_running    <= (w_state_nxt == S_RUN);
        end
    end

    assign min_tens    = r_mt;
    assign min_ones    = r_mo;
    assign sec_tens    = r_st;
    assign sec_ones    = r_so;
    assign digit_blank = r_blank;
    assign running     = r_running;
    assign state       = r_state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven and sequence checks for stopwatch_ctrl
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst, tick_1hz, tick_2hz, tick_blink, btn_pause, btn_reset, sw_adj, sw_sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, digit_blank;
    logic       running;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MIN_TENS_MAX(9)) dut (
        .clk(clk), .rst(rst),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
        .btn_pause(btn_pause), .btn_reset(btn_reset),
        .sw_adj(sw_adj), .sw_sel(sw_sel),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .digit_blank(digit_blank), .running(running), .state(state)
    );

    typedef struct {
        logic        rst, t1, t2, tb, bp, br, adj, sel;
        logic [15:0] tm;
        logic [1:0]  st;
        logic [3:0]  blank;
        logic        run;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic [7:0] in, input logic [15:0] tm,
                                input logic [1:0] st, input logic [3:0] blank,
                                input logic run);
        vec_t v;
        {v.rst, v.t1, v.t2, v.tb, v.bp, v.br, v.adj, v.sel} = in;
        v.tm = tm; v.st = st; v.blank = blank; v.run = run;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] tm, input logic [1:0] st,
                           input logic [3:0] blank, input logic run);
        chk({name, ".time"},    {min_tens, min_ones, sec_tens, sec_ones}, tm);
        chk({name, ".state"},   16'(state), 16'(st));
        chk({name, ".blank"},   16'(digit_blank), 16'(blank));
        chk({name, ".running"}, 16'(running), 16'(run));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {tick_1hz, tick_2hz, tick_blink, btn_pause, btn_reset, sw_adj, sw_sel} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse_t1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1; cyc();
            tick_1hz = 1'b0; cyc();
        end
    endtask

    task automatic pulse_t2(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1; cyc();
            tick_2hz = 1'b0; cyc();
        end
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; cyc();
        btn_pause = 1'b0; cyc();
    endtask

    initial begin
        //            rst t1 t2 tb bp br adj sel
        vecs[0]  = mk(8'b1111_1111, 16'h0000, 2'd0, 4'b0000, 1'b0);
        vecs[1]  = mk(8'b1000_0000, 16'h0000, 2'd0, 4'b0000, 1'b0);
        vecs[2]  = mk(8'b0100_0000, 16'h0000, 2'd0, 4'b0000, 1'b0);
        vecs[3]  = mk(8'b0000_1000, 16'h0000, 2'd1, 4'b0000, 1'b1);
        vecs[4]  = mk(8'b0100_1000, 16'h0001, 2'd1, 4'b0000, 1'b1);
        vecs[5]  = mk(8'b0000_1000, 16'h0001, 2'd1, 4'b0000, 1'b1);
        vecs[6]  = mk(8'b0100_0000, 16'h0002, 2'd1, 4'b0000, 1'b1);
        vecs[7]  = mk(8'b0000_1000, 16'h0002, 2'd2, 4'b0000, 1'b0);
        vecs[8]  = mk(8'b0100_0000, 16'h0002, 2'd2, 4'b0000, 1'b0);
        vecs[9]  = mk(8'b0000_0000, 16'h0002, 2'd2, 4'b0000, 1'b0);
        vecs[10] = mk(8'b0100_1000, 16'h0002, 2'd1, 4'b0000, 1'b1);
        vecs[11] = mk(8'b0000_0000, 16'h0002, 2'd1, 4'b0000, 1'b1);
        vecs[12] = mk(8'b0100_0000, 16'h0003, 2'd1, 4'b0000, 1'b1);
        vecs[13] = mk(8'b0000_0100, 16'h0000, 2'd0, 4'b0000, 1'b0);
        vecs[14] = mk(8'b0000_0011, 16'h0000, 2'd3, 4'b0000, 1'b0);
        vecs[15] = mk(8'b0010_0011, 16'h0001, 2'd3, 4'b0000, 1'b0);
        vecs[16] = mk(8'b0001_0011, 16'h0001, 2'd3, 4'b0011, 1'b0);
        vecs[17] = mk(8'b0011_0010, 16'h0101, 2'd3, 4'b1100, 1'b0);
        vecs[18] = mk(8'b0000_0010, 16'h0101, 2'd3, 4'b1100, 1'b0);
        vecs[19] = mk(8'b0001_0010, 16'h0101, 2'd3, 4'b0000, 1'b0);
        vecs[20] = mk(8'b0000_0110, 16'h0000, 2'd3, 4'b0000, 1'b0);
        vecs[21] = mk(8'b0000_0100, 16'h0000, 2'd2, 4'b0000, 1'b0);
        vecs[22] = mk(8'b0000_1000, 16'h0000, 2'd1, 4'b0000, 1'b1);
        vecs[23] = mk(8'b0000_0000, 16'h0000, 2'd1, 4'b0000, 1'b1);

        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 24; i++) begin
            {rst, tick_1hz, tick_2hz, tick_blink, btn_pause, btn_reset, sw_adj, sw_sel} =
                {vecs[i].rst, vecs[i].t1, vecs[i].t2, vecs[i].tb,
                 vecs[i].bp, vecs[i].br, vecs[i].adj, vecs[i].sel};
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i].tm, vecs[i].st, vecs[i].blank, vecs[i].run);
        end

        // 75 seconds of running, then a long pause hold must toggle only once
        do_reset();
        press_pause();
        pulse_t1(75);
        chk_all("run75", 16'h0115, 2'd1, 4'b0000, 1'b1);
        btn_pause = 1'b1;
        repeat (10) cyc();
        chk_all("hold_pause", 16'h0115, 2'd2, 4'b0000, 1'b0);
        btn_pause = 1'b0;
        cyc();

        // tick and pause in the same cycle while running
        do_reset();
        press_pause();
        pulse_t1(9);
        chk("at9", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0009);
        tick_1hz = 1'b1; btn_pause = 1'b1;
        cyc();
        chk_all("tick_pause", 16'h0010, 2'd2, 4'b0000, 1'b0);
        tick_1hz = 1'b0; btn_pause = 1'b0;
        cyc();
        pulse_t1(3);
        chk_all("paused_ticks", 16'h0010, 2'd2, 4'b0000, 1'b0);

        // seconds adjust wraps without minute carry; blink mask follows sw_sel
        do_reset();
        sw_adj = 1'b1; sw_sel = 1'b1;
        cyc();
        pulse_t2(58);
        chk("adj58", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0058);
        pulse_t2(3);
        chk_all("adj_wrap", 16'h0001, 2'd3, 4'b0000, 1'b0);
        tick_blink = 1'b1;
        cyc();
        chk("blank_sec", 16'(digit_blank), 16'h0003);
        sw_sel = 1'b0;
        cyc();
        chk("blank_min", 16'(digit_blank), 16'h000c);
        sw_adj = 1'b0;
        cyc();
        chk_all("adj_exit", 16'h0001, 2'd2, 4'b0000, 1'b0);

        // top count
        do_reset();
        sw_adj = 1'b1;
        cyc();
        pulse_t2(99);
        chk("adj_min99", {min_tens, min_ones, sec_tens, sec_ones}, 16'h9900);
        sw_sel = 1'b1;
        pulse_t2(59);
        chk("adj_9959", {min_tens, min_ones, sec_tens, sec_ones}, 16'h9959);
        sw_adj = 1'b0;
        cyc();
        press_pause();
        chk("top_run", 16'(state), 16'd1);
        pulse_t1(1);
`ifdef STOPWATCH_SAT_EN
        chk_all("top_tick", 16'h9959, 2'd2, 4'b0000, 1'b0);
        press_pause();
        pulse_t1(1);
        chk_all("top_frozen", 16'h9959, 2'd2, 4'b0000, 1'b0);
`else
        chk_all("top_tick", 16'h0000, 2'd1, 4'b0000, 1'b1);
`endif

        // clear while running at 12:34
        do_reset();
        sw_adj = 1'b1; sw_sel = 1'b0;
        cyc();
        pulse_t2(12);
        sw_sel = 1'b1;
        pulse_t2(34);
        sw_adj = 1'b0;
        cyc();
        press_pause();
        chk_all("run1234", 16'h1234, 2'd1, 4'b0000, 1'b1);
        btn_reset = 1'b1;
        cyc();
        chk_all("clear_run", 16'h0000, 2'd0, 4'b0000, 1'b0);
        btn_reset = 1'b0;
        cyc();

        // reset asserted mid-run with other inputs active
        press_pause();
        pulse_t1(2);
        rst = 1'b1; tick_1hz = 1'b1; btn_pause = 1'b1; sw_adj = 1'b1;
        cyc();
        chk_all("rst_midrun", 16'h0000, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        clear_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mode controller and time-keeping datapath for the stopwatch. Sits between the clock divider and the 7-segment display driver.
- Consumes the divider's toggling 1 Hz, 2 Hz and blink outputs as level inputs and converts them to single-cycle strobes by edge detection.
- Sequences an MM:SS BCD counter through idle, run, pause and adjust modes from debounced buttons and switches.
- Drives the digit values and per-digit blank mask to the display.

Parameters:
- MIN_TENS_MAX, 9: highest legal minutes-tens digit (1..9); top count is MIN_TENS_MAX9:59.

Ports:
- clk  in  1  system clock (100 MHz board clock)
- rst  in  1  reset; synchronous, active-high
- tick_1hz  in  1  divider 1 Hz toggle output; each rising edge = 1 count second
- tick_2hz  in  1  divider 2 Hz toggle output; each rising edge = 1 adjust step
- tick_blink  in  1  divider blink toggle output
- btn_pause  in  1  debounced pause/start button, level
- btn_reset  in  1  debounced clear button, level
- sw_adj  in  1  adjust-mode switch, level
- sw_sel  in  1  adjust field select: 0 = minutes, 1 = seconds
- min_tens  out  4  BCD
- min_ones  out  4  BCD
- sec_tens  out  4  BCD, 0..5
- sec_ones  out  4  BCD
- digit_blank  out  4  bit3 = min_tens … bit0 = sec_ones; 1 = blank digit
- running  out  1  high only in RUN
- state  out  2  IDLE = 0, RUN = 1, PAUSE = 2, ADJ = 3

Behaviour:
- One clock; reset is synchronous and active-high. All logic on posedge clk. No other clocks; divider outputs are never used as clocks.
- Edge detection:
  - Each of tick_1hz, tick_2hz, tick_blink, btn_pause and btn_reset has a prev register.
  - rise = in & ~prev, evaluated combinationally in the current cycle.
  - Registers and outputs update on the next posedge, so latency is 1 clk from first-high sample.
  - A held level produces exactly one rise.
- Reset values:
  - All prev registers 0; every BCD digit 0.
  - state = IDLE, running = 0, digit_blank = 0000, blink_ph = 0.
- blink_ph toggles on each tick_blink rise in every state.
- Transitions are evaluated from the registered state at the start of the cycle. Priority: rst > sw_adj > btn_reset rise > btn_pause rise.
  - sw_adj = 1 in any state: go to (or stay in) ADJ.
  - ADJ with sw_adj = 0: go to PAUSE. Digits are kept.
  - btn_reset rise, not in ADJ: all digits cleared, go to IDLE.
  - btn_reset rise in ADJ: all digits cleared, stay in ADJ.
  - btn_pause rise: IDLE→RUN, RUN→PAUSE, PAUSE→RUN. Ignored in ADJ.
- Counting:
  - Happens only when the registered state is RUN and tick_1hz rises.
  - Same-cycle pause press plus tick in RUN: the count applies and the state moves to PAUSE.
  - Same-cycle pause press plus tick in PAUSE: no count.
  - Same-cycle reset press plus tick: clear wins.
- Increment chain:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - From MIN_TENS_MAX9:59, wrap to 00:00 (see Optional Feature).
- Adjust (ADJ, tick_2hz rise):
  - sw_sel = 1: seconds field +1, 59→00. No carry into minutes.
  - sw_sel = 0: minutes field +1, MIN_TENS_MAX9→00.
  - The selected field changes in the same cycle sw_sel changes.
- digit_blank:
  - ADJ and blink_ph = 1: sw_sel = 0 gives 1100, sw_sel = 1 gives 0011.
  - All other cases: 0000. Registered.
- running = (state == RUN). Registered with state.
- rst asserted mid-run or mid-adjust: reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro: STOPWATCH_SAT_EN.
- Defined: a count from MIN_TENS_MAX9:59 holds the digits at MIN_TENS_MAX9:59 and forces state to PAUSE. Further pause presses re-enter RUN but the digits stay frozen until reset or adjust. The adjust path wraps as normal.
- Undefined: the count wraps to 00:00 and stays in RUN.

Test Plan:
- rst for 2 cycles with all inputs toggling → digits 0000, state 0, digit_blank 0000, running 0.
- btn_pause rise from IDLE, then 75 tick_1hz rises → state 1, display 01:15. Holding btn_pause high 10 cycles → exactly one transition.
- In RUN at 00:09, tick_1hz rise and btn_pause rise in the same cycle → 00:10 and state 2. Further ticks → no change.
- sw_adj = 1, sw_sel = 1 from 00:58, 3 tick_2hz rises → 00:01 (no minute carry). blink_ph = 1 → digit_blank 0011. sw_sel = 0 → 1100. sw_adj = 0 → state 2.
- Load 99:59 via adjust, run, one tick_1hz rise → 00:00 and state 1 without the macro; 99:59 and state 2 with STOPWATCH_SAT_EN.
- btn_reset rise while RUN at 12:34 → next cycle 00:00, state 0. btn_reset rise in ADJ → 00:00, state stays 3.
